md_unit: RTL and testbench
==========================

# md_unit

Multi-cycle multiply/divide unit in the EX stage of the pipelined MIPS CPU; owns the HI/LO registers. It executes MULT/MULTU/DIV/DIVU over a fixed latency and services MTHI/MTLO/MFHI/MFLO. It drives `BusyE`, the busy indication the hazard unit combines with `IsMdD` to stall any mult/div-class instruction in Decode.

## Interface
- `MULT_CYCLES`, 5: busy cycles for MULT/MULTU, ≥1.
- `DIV_CYCLES`, 10: busy cycles for DIV/DIVU, ≥1.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `StartE`  in  1  valid mult/div-class instruction in EX this cycle; already gated by pipeline flush.
- `MdOpE`  in  3  operation code (package constants).
- `SrcAE`  in  32  forwarded rs value.
- `SrcBE`  in  32  forwarded rt value.
- `BusyE`  out  1  `StartE` of MULT/MULTU/DIV/DIVU, or countdown nonzero.
- `Hi`, `Lo`  out  32  architectural HI/LO registers.
- `MdResultE`  out  32  `Hi` when `MdOpE`=MFHI, else `Lo`; combinational.

## Operation
- Op codes: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5, MFHI=6, MFLO=7.
- State: `Count` (counter, 0 = idle), pending `PendHi`/`PendLo`, `PendWe` (commit enable).
- Idle + `StartE` + arithmetic op: result computed from SrcAE/SrcBE, latched into Pend regs. `Count` loads MULT_CYCLES or DIV_CYCLES.
- Busy (`Count`≠0): decrement each cycle. On the edge where `Count`==1, HI/LO ← Pend regs if `PendWe`, and `Count` → 0.
- MULT: signed 64-bit product; MULTU: unsigned. HI = bits 63:32, LO = 31:0.
- DIV/DIVU: LO = quotient, HI = remainder. Signed quotient truncates toward zero and the remainder takes the dividend's sign.
- 0x80000000 / 0xFFFFFFFF (DIV): LO=0x80000000, HI=0. No trap.
- Divide by zero: full DIV_CYCLES busy, `PendWe`=0, HI/LO unchanged.
- MTHI/MTLO with `StartE`: HI or LO ← SrcAE at that edge. No busy cycles. `BusyE` not raised by these ops.
- MFHI/MFLO: no state change; data on `MdResultE`.
- `StartE` while `Count`≠0 is illegal; the hazard unit prevents it. If it occurs anyway, it is ignored entirely: no HI/LO write and no reload.
- `reset`: Count=0, PendWe=0, Pend regs=0, HI=LO=0. A reset during an operation cancels it with no commit.
- Reset values of outputs: `BusyE`=StartE-derived (0 with StartE=0), `Hi`=`Lo`=0, `MdResultE`=0.

## Timing
- `StartE` of MULT in cycle t:
  - `BusyE`=1 in cycles t..t+5, falling to 0 at t+6.
  - New HI/LO are visible from cycle t+6.
  - DIV follows the same pattern with 10: busy t..t+10, results at t+11.
- `BusyE` includes combinational `StartE`. An MFHI in Decode during cycle t therefore stalls, and reaches EX no earlier than cycle t+6 (mult).
- MTHI/MTLO at t: visible on `Hi`/`Lo` and `MdResultE` at t+1. Back-to-back MTHI then MFHI needs no stall.
- Reading HI/LO through `MdResultE` in the commit cycle (Count==1) returns the old value. This case cannot occur, since BusyE stalls the reader.

## Structure
- Shared package `md_pkg`: op-code constants, `MD_OP_W`=3, default latency constants. The decoder and hazard logic import it.
- No sub-module required. Optional `md_arith`: combinational signed/unsigned mult/div producing {hi, lo, div_by_zero}, which keeps the sequencing in `md_unit` small.

## Test plan
- MULT 0xFFFFFFFF × 0x00000002 → BusyE high 6 cycles (including start); then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- MULTU same operands → HI=0x00000001, LO=0xFFFFFFFE.
- DIV 0xFFFFFFF9 (−7) / 2 → after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 → LO=3, HI=1.
- DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0. DIVU 5/0 with prior HI=LO=0x1234 → 10 busy cycles, HI/LO still 0x1234.
- MTHI 0xAAAA5555 then MTLO 0x0F0F0F0F on consecutive cycles → BusyE never high. MFHI/MFLO via MdResultE return those values the cycle after each write.
- reset asserted at busy cycle 3 of a DIV → next cycle Count=0, BusyE=0, HI=LO=0, no later commit. A StartE injected mid-busy changes nothing.

Source files
------------

// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : md_pkg
//  Purpose  : Shared definitions for the multiply/divide unit: op-code
//             encoding, op-code width, default latencies and the bundled
//             arithmetic result type. Imported by md_unit, md_arith, the
//             decoder and the hazard logic.
//  Revision : 1.0  initial release
// ============================================================================
package md_pkg;

    localparam int MD_OP_W = 3;

    typedef enum logic [MD_OP_W-1:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5,
        MD_MFHI  = 3'd6,
        MD_MFLO  = 3'd7
    } md_op_e;

    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

    // Arithmetic ops occupy codes 0..3, so bit 2 clear identifies them.
    function automatic logic md_is_arith(input logic [MD_OP_W-1:0] op);
        return ~op[MD_OP_W-1];
    endfunction

endpackage : md_pkg
`default_nettype wire

// File: rtl/md_arith.sv
`default_nettype none
// ============================================================================
//  Module   : md_arith
//  Purpose  : Combinational signed/unsigned 32x32 multiply and divide.
//  Ports    : i_op          op code (only MULT/MULTU/DIV/DIVU meaningful)
//             i_a, i_b      operands (rs, rt)
//             o_hi, o_lo    product {hi,lo} or {remainder,quotient}
//             o_div_by_zero divide op with zero divisor
//  Revision : 1.0  initial release
// ============================================================================
module md_arith
    import md_pkg::*;
(
    input  logic [MD_OP_W-1:0] i_op,
    input  logic [31:0]        i_a,
    input  logic [31:0]        i_b,
    output logic [31:0]        o_hi,
    output logic [31:0]        o_lo,
    output logic               o_div_by_zero
);

    logic        w_signed;
    logic        w_is_div;
    logic [63:0] w_a_ext;
    logic [63:0] w_b_ext;
    logic [63:0] w_prod;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_b_safe;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    assign w_signed = (i_op == MD_MULT) || (i_op == MD_DIV);
    assign w_is_div = (i_op == MD_DIV)  || (i_op == MD_DIVU);

    // Extending both operands to 64 bits and keeping the low 64 bits of the
    // product gives the correct result for both signed and unsigned forms.
    assign w_a_ext = {{32{w_signed & i_a[31]}}, i_a};
    assign w_b_ext = {{32{w_signed & i_b[31]}}, i_b};
    assign w_prod  = w_a_ext * w_b_ext;

    // Divide on magnitudes and restore signs afterwards. Negating 0x80000000
    // yields 0x80000000, which read as unsigned is the correct magnitude, so
    // the 0x80000000 / -1 overflow case falls out as quotient 0x80000000.
    assign w_a_neg  = w_signed & i_a[31];
    assign w_b_neg  = w_signed & i_b[31];
    assign w_a_mag  = w_a_neg ? (32'd0 - i_a) : i_a;
    assign w_b_mag  = w_b_neg ? (32'd0 - i_b) : i_b;

    assign o_div_by_zero = w_is_div && (i_b == 32'd0);
    // Substitute a harmless divisor so the divider never sees zero.
    assign w_b_safe = (i_b == 32'd0) ? 32'd1 : w_b_mag;
    assign w_q_mag  = w_a_mag / w_b_safe;
    assign w_r_mag  = w_a_mag % w_b_safe;

    // Quotient truncates toward zero; remainder follows the dividend's sign.
    assign w_quot = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_rem  = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

    always_comb begin
        o_hi = w_prod[63:32];
        o_lo = w_prod[31:0];
        if (w_is_div) begin
            o_hi = w_rem;
            o_lo = w_quot;
        end
    end

endmodule : md_arith
`default_nettype wire

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
//  Module   : md_unit
//  Purpose  : EX-stage multi-cycle multiply/divide unit owning HI/LO.
//             Arithmetic results are computed at start, held in pending
//             registers and committed to HI/LO when the countdown expires.
//  Ports    : clk, reset   clock, synchronous active-high reset
//             StartE       valid mult/div-class instruction in EX
//             MdOpE        op code (md_pkg::md_op_e)
//             SrcAE, SrcBE forwarded rs / rt
//             BusyE        arithmetic start this cycle or countdown running
//             Hi, Lo       architectural HI/LO
//             MdResultE    Hi for MFHI, otherwise Lo
//  Revision : 1.0  initial release
// ============================================================================
module md_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               StartE,
    input  logic [MD_OP_W-1:0] MdOpE,
    input  logic [31:0]        SrcAE,
    input  logic [31:0]        SrcBE,
    output logic               BusyE,
    output logic [31:0]        Hi,
    output logic [31:0]        Lo,
    output logic [31:0]        MdResultE
);

    localparam int c_CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_MULT = c_CNT_W'(MULT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_DIV  = c_CNT_W'(DIV_CYCLES);

    logic [c_CNT_W-1:0] r_count_q,   w_count_d;
    logic [31:0]        r_pend_hi_q, w_pend_hi_d;
    logic [31:0]        r_pend_lo_q, w_pend_lo_d;
    logic               r_pend_we_q, w_pend_we_d;
    logic [31:0]        r_hi_q,      w_hi_d;
    logic [31:0]        r_lo_q,      w_lo_d;

    logic [31:0] w_arith_hi;
    logic [31:0] w_arith_lo;
    logic        w_div_by_zero;
    logic        w_idle;

    md_arith u_arith (
        .i_op          (MdOpE),
        .i_a           (SrcAE),
        .i_b           (SrcBE),
        .o_hi          (w_arith_hi),
        .o_lo          (w_arith_lo),
        .o_div_by_zero (w_div_by_zero)
    );

    assign w_idle = (r_count_q == '0);

    always_comb begin
        w_count_d   = r_count_q;
        w_pend_hi_d = r_pend_hi_q;
        w_pend_lo_d = r_pend_lo_q;
        w_pend_we_d = r_pend_we_q;
        w_hi_d      = r_hi_q;
        w_lo_d      = r_lo_q;

        if (!w_idle) begin
            // Any StartE arriving here is illegal and is dropped entirely.
            w_count_d = r_count_q - c_CNT_ONE;
            if ((r_count_q == c_CNT_ONE) && r_pend_we_q) begin
                w_hi_d = r_pend_hi_q;
                w_lo_d = r_pend_lo_q;
            end
        end else if (StartE) begin
            case (MdOpE)
                MD_MULT, MD_MULTU: begin
                    w_count_d   = c_CNT_MULT;
                    w_pend_hi_d = w_arith_hi;
                    w_pend_lo_d = w_arith_lo;
                    w_pend_we_d = 1'b1;
                end
                MD_DIV, MD_DIVU: begin
                    // A zero divisor still occupies the full latency but
                    // leaves HI/LO untouched.
                    w_count_d   = c_CNT_DIV;
                    w_pend_hi_d = w_arith_hi;
                    w_pend_lo_d = w_arith_lo;
                    w_pend_we_d = ~w_div_by_zero;
                end
                MD_MTHI: w_hi_d = SrcAE;
                MD_MTLO: w_lo_d = SrcAE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count_q   <= '0;
            r_pend_hi_q <= '0;
            r_pend_lo_q <= '0;
            r_pend_we_q <= 1'b0;
            r_hi_q      <= '0;
            r_lo_q      <= '0;
        end else begin
            r_count_q   <= w_count_d;
            r_pend_hi_q <= w_pend_hi_d;
            r_pend_lo_q <= w_pend_lo_d;
            r_pend_we_q <= w_pend_we_d;
            r_hi_q      <= w_hi_d;
            r_lo_q      <= w_lo_d;
        end
    end

    // StartE is folded in combinationally so a mult/div-class instruction
    // sitting in Decode stalls in the very cycle the operation is issued.
    assign BusyE     = (StartE && md_is_arith(MdOpE)) || !w_idle;
    assign Hi        = r_hi_q;
    assign Lo        = r_lo_q;
    assign MdResultE = (MdOpE == MD_MFHI) ? r_hi_q : r_lo_q;

endmodule : md_unit
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_md_unit
//  Purpose  : Self-checking bench for md_unit. A transaction-level model
//             tracks HI/LO and the absolute cycle at which each operation's
//             busy window ends; outputs are compared every cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_md_unit;
    import md_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        StartE;
    logic [2:0]  MdOpE;
    logic [31:0] SrcAE;
    logic [31:0] SrcBE;
    logic        BusyE;
    logic [31:0] Hi;
    logic [31:0] Lo;
    logic [31:0] MdResultE;

    always #5 clk = ~clk;

    md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk       (clk),
        .reset     (reset),
        .StartE    (StartE),
        .MdOpE     (MdOpE),
        .SrcAE     (SrcAE),
        .SrcBE     (SrcBE),
        .BusyE     (BusyE),
        .Hi        (Hi),
        .Lo        (Lo),
        .MdResultE (MdResultE)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          busy_end = -1;   // last cycle in which the running op is busy
    int          busy_seen = 0;
    bit          m_pend_we = 1'b0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [31:0] m_phi = 32'd0;
    logic [31:0] m_plo = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference arithmetic from plain 64-bit integer math.
    function automatic void model_arith(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, output logic [31:0] hi,
                                        output logic [31:0] lo, output bit ok);
        longint sa, sb, ua, ub, p, q, r;
        sa = longint'(int'(a));
        sb = longint'(int'(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        ok = 1'b1;
        p = 0; q = 0; r = 0;
        case (op)
            3'd0: p = sa * sb;
            3'd1: p = ua * ub;
            3'd2: if (b != 0) begin q = sa / sb; r = sa % sb; end
            default: if (b != 0) begin q = ua / ub; r = ua % ub; end
        endcase
        if (op < 3'd2) begin
            hi = p[63:32];
            lo = p[31:0];
        end else begin
            ok = (b != 0);
            hi = r[31:0];
            lo = q[31:0];
        end
    endfunction

    // One clock cycle: drive, compare at the falling edge, advance the model.
    task automatic step(input bit rst, input bit st, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b);
        bit ok;
        bit exp_busy;
        reset  = rst;
        StartE = st;
        MdOpE  = op;
        SrcAE  = a;
        SrcBE  = b;
        @(negedge clk);
        exp_busy = (st && op < 3'd4) || (cyc <= busy_end);
        chk("busy", {31'd0, BusyE}, {31'd0, exp_busy});
        chk("hi", Hi, m_hi);
        chk("lo", Lo, m_lo);
        chk("mdresult", MdResultE, (op == 3'd6) ? m_hi : m_lo);
        if (BusyE) busy_seen++;
        @(posedge clk);
        if (rst) begin
            m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_pend_we = 0; busy_end = -1;
        end else begin
            if (cyc == busy_end && m_pend_we) begin
                m_hi = m_phi;
                m_lo = m_plo;
            end
            if (cyc > busy_end && st) begin
                if (op < 3'd4) begin
                    model_arith(op, a, b, m_phi, m_plo, ok);
                    m_pend_we = ok;
                    busy_end  = cyc + ((op < 3'd2) ? MC : DC);
                end else if (op == 3'd4) begin
                    m_hi = a;
                end else if (op == 3'd5) begin
                    m_lo = a;
                end
            end
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd7, 32'd0, 32'd0);
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        reset = 1'b1; StartE = 1'b0; MdOpE = 3'd7; SrcAE = 0; SrcBE = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        idle(1);

        // MULT -1 * 2
        busy_seen = 0;
        step(0, 1, 3'd0, 32'hFFFF_FFFF, 32'd2);
        idle(8);
        chk("mult_busy_cycles", busy_seen, 32'd6);
        chk("model_mult_hi", m_hi, 32'hFFFF_FFFF);
        chk("model_mult_lo", m_lo, 32'hFFFF_FFFE);
        chk("mult_hi_lit", Hi, 32'hFFFF_FFFF);

        // MULTU same operands
        step(0, 1, 3'd1, 32'hFFFF_FFFF, 32'd2);
        idle(8);
        chk("multu_hi_lit", Hi, 32'h0000_0001);
        chk("multu_lo_lit", Lo, 32'hFFFF_FFFE);

        // DIV -7 / 2
        busy_seen = 0;
        step(0, 1, 3'd2, 32'hFFFF_FFF9, 32'd2);
        idle(12);
        chk("div_busy_cycles", busy_seen, 32'd11);
        chk("model_div_lo", m_lo, 32'hFFFF_FFFD);
        chk("div_hi_lit", Hi, 32'hFFFF_FFFF);

        // DIVU 7 / 2
        step(0, 1, 3'd3, 32'd7, 32'd2);
        idle(12);
        chk("divu_lo_lit", Lo, 32'd3);
        chk("divu_hi_lit", Hi, 32'd1);

        // Signed overflow case
        step(0, 1, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        idle(12);
        chk("divovf_lo_lit", Lo, 32'h8000_0000);
        chk("divovf_hi_lit", Hi, 32'd0);

        // Divide by zero keeps HI/LO
        step(0, 1, 3'd4, 32'h1234, 32'd0);
        step(0, 1, 3'd5, 32'h1234, 32'd0);
        busy_seen = 0;
        step(0, 1, 3'd3, 32'd5, 32'd0);
        idle(12);
        chk("dbz_busy_cycles", busy_seen, 32'd11);
        chk("dbz_hi_lit", Hi, 32'h1234);
        chk("dbz_lo_lit", Lo, 32'h1234);

        // MTHI / MTLO back to back, no busy
        busy_seen = 0;
        step(0, 1, 3'd4, 32'hAAAA_5555, 32'd0);
        step(0, 1, 3'd5, 32'h0F0F_0F0F, 32'd0);
        MdOpE = 3'd6; #1;
        chk("mfhi_lit", MdResultE, 32'hAAAA_5555);
        MdOpE = 3'd7; #1;
        chk("mflo_lit", MdResultE, 32'h0F0F_0F0F);
        chk("mt_busy_cycles", busy_seen, 32'd0);
        idle(1);

        // Illegal starts mid-busy are ignored
        step(0, 1, 3'd0, 32'd3, 32'd4);
        step(0, 1, 3'd4, 32'hDEAD_BEEF, 32'd0);
        step(0, 1, 3'd2, 32'd100, 32'd7);
        idle(8);
        chk("ignored_hi_lit", Hi, 32'd0);
        chk("ignored_lo_lit", Lo, 32'd12);

        // Reset during DIV cancels it
        step(0, 1, 3'd2, 32'd100, 32'd7);
        idle(2);
        step(1, 0, 3'd7, 32'd0, 32'd0);
        idle(12);
        chk("rst_hi_lit", Hi, 32'd0);
        chk("rst_lo_lit", Lo, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 2500; i++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) != 0),
                 3'($urandom_range(0, 7)), rnd_opnd(), rnd_opnd());
        end
        idle(12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_md_unit
`default_nettype wire
